// File: rtl/buffered_instruction_fetch.sv
// Fetch stage with a small instruction queue in front of Decode.
// The stage keeps the PC and allows one memory request in flight at a time.
// Words that come back are queued together with their fetch address.
// A redirect from Decode (jump or taken branch) empties the queue, and any
// response still in flight is thrown away when it arrives.
module buffered_instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hazard,
  input  logic                  outputBrachControlInput,
  input  logic [ADDR_WIDTH-1:0] pcBranchInput,
  input  logic                  jumpInput,
  input  logic [ADDR_WIDTH-1:0] pcJumpInput,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemReady,
  input  logic                  imemValid,
  input  logic [31:0]           imemData,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc4Output,
  output logic                  instrValid
);

  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // nothing outstanding
    ST_WAIT  = 2'd1,  // one request outstanding, its word will be queued
    ST_DRAIN = 2'd2   // one request outstanding, its word will be dropped
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] req_addr_r;
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [31:0]           word_q_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q_r [FIFO_DEPTH];

  logic                  redirect_s;
  logic [ADDR_WIDTH-1:0] target_raw_s;
  logic [ADDR_WIDTH-1:0] target_s;
  logic                  issue_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;

  // Pick the redirect target. A jump wins over a branch, and the target is forced to word alignment.
  always_comb begin
    redirect_s = jumpInput | outputBrachControlInput;
    if (jumpInput) begin
      target_raw_s = pcJumpInput;
    end else begin
      target_raw_s = pcBranchInput;
    end
    target_s = target_raw_s & ~ADDR_WIDTH'(3);
  end

  // Decide whether to request a word. Free space is judged from the registered
  // count only, so a pop in the same cycle does not make room early.
  always_comb begin
    issue_s = 1'b0;
    if (reset || redirect_s) begin
      issue_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  issue_s = (count_r < DEPTH_C);
        ST_WAIT:  issue_s = imemValid && ((count_r + CNT_W'(1)) < DEPTH_C);
        ST_DRAIN: issue_s = 1'b0;
        default:  issue_s = 1'b0;
      endcase
    end
  end

  // Handshake events for this cycle. A redirect blocks all queue traffic.
  always_comb begin
    accept_s = issue_s & imemReady;
    push_s   = !redirect_s && (state_r == ST_WAIT) && imemValid;
    pop_s    = !redirect_s && (count_r != '0) && !hazard;
  end

  assign imemReq  = issue_s;
  assign imemAddr = pc_r;

  // Track the PC, the address of the request in flight, and the state of the
  // outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
    end else begin
      if (redirect_s) begin
        pc_r <= target_s;
      end else if (accept_s) begin
        pc_r <= pc_r + ADDR_WIDTH'(4);
      end else begin
        pc_r <= pc_r;
      end

      if (accept_s) begin
        req_addr_r <= pc_r;
      end else begin
        req_addr_r <= req_addr_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (redirect_s) begin
            // The word in flight now belongs to the wrong path.
            state_r <= imemValid ? ST_IDLE : ST_DRAIN;
          end else if (accept_s) begin
            state_r <= ST_WAIT;
          end else if (imemValid) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (imemValid) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Update the queue pointers and the occupancy count. A redirect empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else if (redirect_s) begin
      count_r  <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Store each returned word together with the address it was fetched from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        word_q_r[i] <= 32'd0;
        addr_q_r[i] <= '0;
      end
    end else if (push_s) begin
      word_q_r[wr_ptr_r] <= imemData;
      addr_q_r[wr_ptr_r] <= req_addr_r;
    end else begin
      word_q_r[wr_ptr_r] <= word_q_r[wr_ptr_r];
      addr_q_r[wr_ptr_r] <= addr_q_r[wr_ptr_r];
    end
  end

  // Present the queue head to Decode. An empty queue shows as a NOP at address 0.
  always_comb begin
    instrValid = (count_r != '0);
    if (instrValid) begin
      instruction = word_q_r[rd_ptr_r];
      pc4Output   = addr_q_r[rd_ptr_r] + ADDR_WIDTH'(4);
    end else begin
      instruction = 32'd0;
      pc4Output   = '0;
    end
  end

endmodule

// File: tb/tb_buffered_instruction_fetch.sv
// Randomised scoreboard bench for buffered_instruction_fetch. The reference
// model is a list of the instruction addresses Decode should receive, in order:
// counting up from the reset PC, and restarting at the aligned target after
// each redirect. The memory model returns word == address.
module tb_buffered_instruction_fetch;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        hazard;
  logic        br;
  logic [31:0] pc_br;
  logic        jp;
  logic [31:0] pc_jp;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [31:0] pc4;
  logic        instr_valid;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] next_exp;
  logic [31:0] mon_e;
  int          n_checks;
  int          n_errors;
  int          n_pops;
  int          cyc;
  int          lat_min;
  int          lat_max;
  bit          last_acc;

  buffered_instruction_fetch #(
    .ADDR_WIDTH(32),
    .RESET_PC  (BASE),
    .FIFO_DEPTH(2)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .hazard                 (hazard),
    .outputBrachControlInput(br),
    .pcBranchInput          (pc_br),
    .jumpInput              (jp),
    .pcJumpInput            (pc_jp),
    .imemReq                (imem_req),
    .imemAddr               (imem_addr),
    .imemReady              (imem_ready),
    .imemValid              (imem_valid),
    .imemData               (imem_data),
    .instruction            (instruction),
    .pc4Output              (pc4),
    .instrValid             (instr_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // One clock cycle. Inputs are driven on the falling edge. The memory model
  // presents a response when the oldest pending request is due, then records
  // any request that will be accepted on the next rising edge.
  task automatic step(input logic hz, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic rdy);
    mreq_t m;
    @(negedge clk);
    cyc++;
    hazard     = hz;
    br         = b;
    pc_br      = bt;
    jp         = j;
    pc_jp      = jt;
    imem_ready = rdy;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_data  = mq[0].addr;
    end else begin
      imem_valid = 1'b0;
      imem_data  = 32'hDEAD_BEEF;
    end
    if (b || j) begin
      exp_q.delete();
      next_exp = (j ? jt : bt) & 32'hFFFF_FFFC;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
    #1;
    if (imem_valid) void'(mq.pop_front());
    last_acc = imem_req && imem_ready;
    if (last_acc) begin
      m.addr = imem_addr;
      m.due  = cyc + int'($urandom_range(lat_max, lat_min));
      mq.push_back(m);
    end
  endtask

  task automatic nstep();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic rand_step();
    logic        b;
    logic        j;
    int unsigned kind;
    b = 1'b0;
    j = 1'b0;
    if ($urandom_range(0, 24) == 0) begin
      kind = $urandom_range(0, 2);
      b = (kind != 1);
      j = (kind != 0);
    end
    step($urandom_range(0, 3) == 0, b, $urandom_range(0, 4095), j, $urandom_range(0, 4095),
         $urandom_range(0, 9) < 7);
  endtask

  // Assert reset, check the outputs it forces, then release it on a falling
  // edge. The memory model is reset together with the DUT.
  task automatic do_reset();
    reset      = 1'b1;
    hazard     = 1'b0;
    br         = 1'b0;
    jp         = 1'b0;
    imem_valid = 1'b0;
    imem_ready = 1'b0;
    #1;
    check("reset_req", {31'd0, imem_req}, 32'd0);
    check("reset_addr", imem_addr, BASE);
    check("reset_valid", {31'd0, instr_valid}, 32'd0);
    check("reset_instr", instruction, 32'd0);
    check("reset_pc4", pc4, 32'd0);
    mq.delete();
    exp_q.delete();
    next_exp = BASE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_acc(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      nstep();
      found = last_acc;
    end
    if (!found) fail_timeout(name);
  endtask

  task automatic wait_req(input string name, input logic [31:0] want);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      nstep();
      if (imem_req) begin
        found = 1'b1;
        check(name, imem_addr, want);
      end
    end
    if (!found) fail_timeout(name);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] want_pc4);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      nstep();
      if (instr_valid) begin
        found = 1'b1;
        check(name, pc4, want_pc4);
      end
    end
    if (!found) fail_timeout(name);
  endtask

  // Monitor: every delivery to Decode is compared with the next expected address.
  always @(negedge clk) begin
    #2;
    if (!reset && instr_valid && !hazard && !(br || jp)) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL stream_underflow: got pc4 %h expected no delivery", pc4);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_instr", instruction, mon_e);
        check("stream_pc4", pc4, mon_e + 32'd4);
      end
    end
  end

  initial begin
    int n;
    n_checks   = 0;
    n_errors   = 0;
    n_pops     = 0;
    cyc        = 0;
    lat_min    = 1;
    lat_max    = 1;
    reset      = 1'b0;
    hazard     = 1'b0;
    br         = 1'b0;
    jp         = 1'b0;
    pc_br      = 32'd0;
    pc_jp      = 32'd0;
    imem_ready = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 32'd0;
    next_exp   = BASE;
    #2;
    do_reset();

    // Start-up with a 1-cycle memory.
    nstep();
    check("c0_req", {31'd0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, BASE);
    nstep();
    check("c1_addr", imem_addr, BASE + 32'd4);
    check("c1_valid", {31'd0, instr_valid}, 32'd0);
    nstep();
    check("c2_valid", {31'd0, instr_valid}, 32'd1);
    check("c2_instr", instruction, BASE);
    check("c2_pc4", pc4, BASE + 32'd4);
    repeat (10) nstep();

    // Hold hazard. The head must stay put, the queue fills, and requests stop.
    for (int h = 1; h <= 6; h++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      if (h >= 4) begin
        check("hazard_valid", {31'd0, instr_valid}, 32'd1);
        check("hazard_head", instruction, exp_q[0]);
        check("hazard_req", {31'd0, imem_req}, 32'd0);
      end
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      if (instr_valid) n++;
    end
    check("hazard_buffered_entries", n, 32'd2);
    repeat (5) nstep();

    // Jump while a request is outstanding, with a 3-cycle memory.
    lat_min = 3;
    lat_max = 3;
    repeat (5) nstep();
    wait_acc("jump_wait_accept");
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b1);
    check("jump_req_low", {31'd0, imem_req}, 32'd0);
    nstep();
    check("jump_flush", {31'd0, instr_valid}, 32'd0);
    wait_req("jump_target_addr", 32'h100);
    wait_valid("jump_first_pc4", 32'h104);
    repeat (6) nstep();

    // Jump wins over branch. A misaligned branch target is aligned down.
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
    wait_req("jump_priority_addr", 32'h80);
    repeat (4) nstep();
    step(1'b0, 1'b1, 32'h43, 1'b0, 32'h0, 1'b1);
    wait_req("branch_align_addr", 32'h40);
    repeat (6) nstep();

    // Random traffic: memory latency 1-5, random ready, random hazards and redirects.
    lat_min = 1;
    lat_max = 5;
    n = n_pops;
    repeat (1000) rand_step();
    repeat (20) nstep();
    n_checks++;
    if (n_pops - n <= 50) begin
      n_errors++;
      $display("FAIL random_throughput: got %0d deliveries expected more than 50", n_pops - n);
    end

    // Asynchronous reset while a request is outstanding.
    lat_min = 3;
    lat_max = 3;
    wait_acc("reset_wait_accept");
    nstep();
    #2;
    do_reset();
    nstep();
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, BASE);
    wait_valid("restart_first_pc4", BASE + 32'd4);
    repeat (15) nstep();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
